// File: rtl/expmod31_if.sv
// expmod31_if
// Request/response bundle for the expmod31 modular exponentiation unit.
//   START  - request strobe, driven by the master, sampled by the unit only when idle
//   BASE   - 5-bit base operand (0..31, 31 behaves as 0)
//   EXP    - EW-bit unsigned exponent
//   BUSY   - unit is iterating
//   DONE   - one-cycle completion pulse, Y is fresh in that cycle
//   Y      - result 0..30, held until the next completion
// The master modport belongs to whoever issues requests. The slave modport belongs to the unit.
interface expmod31_if #(
  parameter int EW = 8
);

  logic          START;
  logic [4:0]    BASE;
  logic [EW-1:0] EXP;
  logic          BUSY;
  logic          DONE;
  logic [4:0]    Y;

  modport master (
    output START,
    output BASE,
    output EXP,
    input  BUSY,
    input  DONE,
    input  Y
  );

  modport slave (
    input  START,
    input  BASE,
    input  EXP,
    output BUSY,
    output DONE,
    output Y
  );

endinterface

// File: rtl/expmod31.sv
// expmod31
// Sequential Y = BASE^EXP mod 31 using right-to-left square-and-multiply.
// Every operation runs exactly EW iterations. The latency is therefore fixed
// regardless of the operand values.
// Ports:
//   CLK   - rising-edge clock
//   RSTN  - asynchronous active-low reset
//   bus   - expmod31_if slave modport (START/BASE/EXP in, BUSY/DONE/Y out)
// The file also holds multmod31. This is the combinational 5-bit modular multiplier.
// The unit instantiates it twice: one copy for the square path and one for the multiply path.

// multmod31
// Combinational p = (a * b) mod 31. The inputs span 0..31 and the output spans 0..30.
// Ports: a, b - 5-bit operands; p - 5-bit residue.
module multmod31 (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [4:0] p
);

  logic [9:0] prod;
  logic [5:0] fold1;
  logic [5:0] fold2;
  logic [5:0] fold2_minus;

  // 32 is congruent to 1 mod 31. The high 5 bits of the product can therefore be added
  // onto the low 5 bits. A second fold and one conditional subtract complete the reduction.
  // The largest product is 961, so fold1 <= 61 and fold2 <= 31.
  always_comb begin
    prod        = {5'd0, a} * {5'd0, b};
    fold1       = {1'b0, prod[9:5]} + {1'b0, prod[4:0]};
    fold2       = {5'd0, fold1[5]} + {1'b0, fold1[4:0]};
    fold2_minus = fold2 - 6'd31;
    if (fold2 >= 6'd31) begin
      p = fold2_minus[4:0];
    end else begin
      p = fold2[4:0];
    end
  end

endmodule

module expmod31 #(
  parameter int EW = 8
) (
  input  logic        CLK,
  input  logic        RSTN,
  expmod31_if.slave   bus
);

  localparam int CW = $clog2(EW + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(EW);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    acc_q,   acc_d;
  logic [4:0]    b_q,     b_d;
  logic [EW-1:0] e_q,     e_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic [4:0]    y_q,     y_d;

  logic [4:0]    mul_p;
  logic [4:0]    sq_p;

  multmod31 u_mul (
    .a (acc_q),
    .b (b_q),
    .p (mul_p)
  );

  multmod31 u_sq (
    .a (b_q),
    .b (b_q),
    .p (sq_p)
  );

  // Next-state logic. In RUN, each cycle consumes one exponent bit, LSB first.
  // Y, DONE and BUSY are computed here as well, so they leave the unit straight from flops.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    y_d     = y_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          b_d     = bus.BASE;
          e_d     = bus.EXP;
          acc_d   = 5'd1;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        acc_d = e_q[0] ? mul_p : acc_q;
        b_d   = sq_p;
        e_d   = e_q >> 1;
        cnt_d = cnt_q - CNT_LAST;
        // The last iteration publishes the accumulator value it is about to store.
        if (cnt_q == CNT_LAST) begin
          y_d     = acc_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register. A reset drops any operation in progress without emitting DONE.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      acc_q   <= 5'd1;
      b_q     <= 5'd0;
      e_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= 5'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      y_q     <= y_d;
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.Y    = y_q;

endmodule

// File: tb/tb_expmod31.sv
// tb_expmod31
// Scoreboard bench for expmod31.
// The driver works out, from the request timing alone, which START edges are accepted.
// For each accepted request it queues the expected result and the edge at which DONE should arrive.
// A separate monitor checks the following on every falling edge:
//   - DONE against the queued results
//   - BUSY against the accepted-request window
//   - Y stays held between completions
module tb_expmod31;

  localparam int EW = 8;

  typedef struct {
    int y;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   next_free;
  int   last_k;
  int   last_y;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  expmod31_if #(.EW(EW)) bus ();

  expmod31 #(.EW(EW)) dut (
    .CLK  (clk),
    .RSTN (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter. At a falling edge, cyc is the number of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Plain repeated multiplication mod 31, with x^0 = 1.
  function automatic int ref_pow(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * (b % 31)) % 31;
    return r;
  endfunction

  task automatic check_output(input string name, input int act, input int req);
    n_checks++;
    if (act == req) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one cycle. Call this at a falling edge. The next rising edge has number cyc+1.
  task automatic apply_stimulus(input bit s, input int b, input int e);
    int k;
    bus.START = s;
    bus.BASE  = 5'(b);
    bus.EXP   = 8'(e);
    if (s && (cyc + 1 >= next_free)) begin
      k = cyc + 1;
      sb.push_back('{y: ref_pow(b, e), cyc: k + EW});
      next_free = k + EW + 2;
      last_k    = k;
    end
    @(negedge clk);
  endtask

  task automatic issue(input int b, input int e);
    for (int i = 0; i < 20 && (cyc + 1 < next_free); i++)
      apply_stimulus(1'b0, $urandom_range(0, 31), $urandom_range(0, 255));
    if (cyc + 1 < next_free) check_output("issue_wait", cyc + 1, next_free);
    apply_stimulus(1'b1, b, e);
  endtask

  // Monitor: decoupled from the driver and fed only by the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_y = 0;
    end else begin
      check_output("busy", int'(bus.BUSY), int'((cyc >= last_k) && (cyc < last_k + EW)));
      check_output("busy_and_done", int'(bus.BUSY && bus.DONE), 0);
      if (bus.DONE) begin
        if (sb.size() == 0) begin
          check_output("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output("y", int'(bus.Y), e.y);
          check_output("latency", cyc, e.cyc);
        end
        last_y = int'(bus.Y);
      end else begin
        check_output("y_hold", int'(bus.Y), last_y);
      end
    end
  end

  initial begin
    int k;
    int dir_b[8] = '{2, 3, 3, 3, 0, 31, 31, 5};
    int dir_e[8] = '{5, 15, 30, 255, 0, 0, 7, 0};

    n_checks  = 0;
    n_pass    = 0;
    cyc       = 0;
    next_free = 0;
    last_k    = -1000;
    last_y    = 0;
    rst_n     = 1'b0;
    bus.START = 1'b0;
    bus.BASE  = 5'd0;
    bus.EXP   = 8'd0;

    // Check the reset state.
    repeat (3) @(negedge clk);
    check_output("rst_busy", int'(bus.BUSY), 0);
    check_output("rst_done", int'(bus.DONE), 0);
    check_output("rst_y", int'(bus.Y), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Directed operands, including the zero-exponent and 0/31 base corners.
    for (int i = 0; i < 8; i++) issue(dir_b[i], dir_e[i]);

    // START held high. Only requests arriving in IDLE are accepted.
    for (int i = 0; i < 40; i++) apply_stimulus(1'b1, 2, 1);
    apply_stimulus(1'b0, 0, 0);

    // Random START pulses during BUSY must not disturb the accepted operands.
    issue(3, 200);
    for (int i = 0; i < 9; i++)
      apply_stimulus(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 255));

    // Reset in the middle of an operation.
    issue(2, 5);
    k = last_k;
    for (int i = 0; i < 10 && cyc < k + 4; i++) apply_stimulus(1'b0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check_output("midrst_busy", int'(bus.BUSY), 0);
    check_output("midrst_done", int'(bus.DONE), 0);
    check_output("midrst_y", int'(bus.Y), 0);
    sb.delete();
    next_free = 0;
    last_k    = -1000;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    issue(2, 10);

    // Every base with the extreme exponents.
    for (int b = 0; b < 32; b++) begin
      issue(b, 0);
      issue(b, 1);
      issue(b, 255);
    end

    // Fully random cycles: START may be high at any time.
    for (int i = 0; i < 600; i++)
      apply_stimulus(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 255));

    // Random back-to-back operations.
    for (int i = 0; i < 800; i++) issue($urandom_range(0, 31), $urandom_range(0, 255));

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 60 && sb.size() > 0; i++) apply_stimulus(1'b0, 0, 0);
    check_output("drain", sb.size(), 0);
    repeat (3) apply_stimulus(1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/expmod31.md
# expmod31

Sequential modular exponentiation unit computing Y = BASE^EXP mod 31 by right-to-left square-and-multiply. It sits directly upstream of and around the combinational `multmod31` multiplier, instantiating two copies (square path, multiply path). Each copy's product is registered back into the datapath every cycle. Latency is fixed, independent of operand values, so downstream consumers can schedule on DONE.

## Interface
- EW, 8: exponent width in bits; also the number of iterations per operation.
- CLK  input  1  rising-edge clock.
- RSTN  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only in IDLE.
- BASE  input  5  base operand, 0..31; 31 is congruent to 0.
- EXP  input  EW  exponent, unsigned.
- BUSY  output  1  high while an operation is in progress (RUN state).
- DONE  output  1  single-cycle pulse; Y is valid and updated.
- Y  output  5  result, 0..30; holds until the next completion.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - If START=1 at an edge, load b_reg=BASE, e_reg=EXP, acc=1, cnt=EW.
  - Go to RUN; BUSY=1.
  - START=0: remain in IDLE.
- RUN, each edge:
  - Multiply-instance inputs are acc and b_reg.
  - Square-instance inputs are b_reg and b_reg.
  - acc <= e_reg[0] ? multmod31(acc,b_reg) : acc.
  - b_reg <= multmod31(b_reg,b_reg).
  - e_reg <= e_reg >> 1.
  - cnt <= cnt-1.
- RUN exit: on the edge where cnt==1 (the last iteration):
  - Y <= next acc value.
  - DONE <= 1, BUSY <= 0.
  - Go to FIN.
- FIN: DONE <= 0, go to IDLE. Exactly EW iterations always run; there is no early exit on e_reg==0.
- START in RUN or FIN: ignored, not queued. BASE and EXP are don't-care outside the accepting edge.
- Arithmetic:
  - All intermediate values stay 5-bit.
  - multmod31 accepts 0..31 and returns 0..30.
  - acc is initialised to 1, so BASE^0 = 1 for every BASE, including 0 and 31.
  - BASE 0 or 31 with EXP>0 gives 0.
- Reset (RSTN low, any time, asynchronous): state=IDLE, BUSY=0, DONE=0, Y=0, acc=1, b_reg=0, e_reg=0, cnt=0.
  - An in-flight operation is discarded with no DONE pulse.
  - After release, the first accepted START behaves normally.

## Timing
- START=1 sampled at edge k: BUSY=1 from edge k.
- Iterations occur at edges k+1..k+EW.
- At edge k+EW: Y updated, DONE=1, BUSY=0.
- At edge k+EW+1: DONE=0, IDLE re-entered.
- Earliest next accepted START: edge k+EW+2.
- Issue interval: EW+2 cycles.
- BUSY and DONE are never simultaneously high. All outputs are registered, with no combinational path from inputs to outputs.
- Critical path: one multmod31 plus a 2:1 mux into acc.

## Test plan
- Reset, then START with BASE=2, EXP=5 -> BUSY high 8 cycles, DONE pulse at edge k+8, Y=1 (32 mod 31).
- BASE=3, EXP=15 -> Y=30. BASE=3, EXP=30 -> Y=1. BASE=3, EXP=255 -> Y=30. DONE always at edge k+8.
- BASE=0, EXP=0 -> Y=1; BASE=31, EXP=0 -> Y=1; BASE=31, EXP=7 -> Y=0; BASE=5, EXP=0 -> Y=1.
- START held high continuously with BASE=2, EXP=1:
  - Starts are accepted only from IDLE, spaced 10 cycles apart.
  - Each accepted start gives Y=2.
  - Pulsing START while BUSY, with different operands, does not alter the result.
- Assert RSTN low at edge k+4 of an operation (BASE=2, EXP=5):
  - All outputs go to 0 immediately, with no DONE.
  - After release, START with BASE=2, EXP=10 -> Y=1 at edge k'+8.
- Exhaustive: all 32 BASE values x all 256 EXP values against a reference model of pow(BASE mod 31, EXP) mod 31 (0^0=1). Check Y only on DONE, check latency every run, and check that Y holds between completions.
